// File: rtl/dsp_operand_feeder_if.sv
// Operand stream and slice-side bundle for dsp_operand_feeder.
// The master drives operands and stall; the slave (feeder) drives the slice-side outputs.
interface dsp_operand_feeder_if #(
    parameter int WIDTH  = 18,
    parameter int ADDR_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic [WIDTH-1:0]  in_d;
    logic [WIDTH-1:0]  out_a;
    logic [WIDTH-1:0]  out_b;
    logic [WIDTH-1:0]  out_d;
    logic              out_ce;
    logic              stall;
    logic              res_valid;
    logic [ADDR_W:0]   fill;

    modport master (
        output in_valid, in_a, in_b, in_d, stall,
        input  in_ready, out_a, out_b, out_d, out_ce, res_valid, fill
    );

    modport slave (
        input  in_valid, in_a, in_b, in_d, stall,
        output in_ready, out_a, out_b, out_d, out_ce, res_valid, fill
    );
endinterface

// File: rtl/dsp_operand_feeder.sv
// Buffers A/B/D triples and issues them into the DSP48A1 slice with a shared clock-enable,
// tracking each one to P with a token pipe. Optional FEEDER_FLUSH_EN adds a flush input.
module dsp_operand_feeder #(
    parameter int WIDTH    = 18,
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 2,
    parameter int PIPE_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef FEEDER_FLUSH_EN
    input  logic                 flush,
`endif
    dsp_operand_feeder_if.slave  bus
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] d;
    } triple_t;

    triple_t               mem_q [DEPTH];
    triple_t               mem_d [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]       fill_q, fill_d;
    triple_t               out_q, out_d;
    logic [PIPE_LAT-1:0]   vld_pipe_q, vld_pipe_d;

    logic full, ce, push, pop;

    assign full         = (fill_q == (ADDR_W+1)'(DEPTH));
    assign ce           = !bus.stall;
    assign bus.in_ready = !rst && !full;
    assign bus.out_ce   = ce;

    // Pop only from what is already stored, so a fresh push never bypasses to out_*.
    assign pop = ce && (fill_q != '0);
`ifdef FEEDER_FLUSH_EN
    assign push = bus.in_valid && bus.in_ready && !flush;
`else
    assign push = bus.in_valid && bus.in_ready;
`endif

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        out_d      = out_q;
        vld_pipe_d = vld_pipe_q;
        fill_d     = fill_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);

        if (push) begin
            mem_d[wr_ptr_q] = '{a: bus.in_a, b: bus.in_b, d: bus.in_d};
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
        end

        // Tokens advance with the slice registers; an empty FIFO issues a bubble.
        if (ce) begin
            vld_pipe_d[0] = pop;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_pipe_d[i] = vld_pipe_q[i-1];
            end
            if (pop) begin
                out_d    = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
        end

`ifdef FEEDER_FLUSH_EN
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fill_d     = '0;
            vld_pipe_d = '0;
            out_d      = out_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            out_q      <= '0;
            vld_pipe_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            out_q      <= out_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    // Storage needs no reset: occupancy is governed by the pointers and fill.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.out_a     = out_q.a;
    assign bus.out_b     = out_q.b;
    assign bus.out_d     = out_q.d;
    assign bus.res_valid = vld_pipe_q[PIPE_LAT-1];
    assign bus.fill      = fill_q;

endmodule

// File: tb/tb_dsp_operand_feeder.sv
// Directed bench for dsp_operand_feeder (WIDTH=18, DEPTH=4, PIPE_LAT=4).
module tb_dsp_operand_feeder;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef FEEDER_FLUSH_EN
    logic flush = 1'b0;
`endif
    int errors = 0;
    int checks = 0;

    dsp_operand_feeder_if #(.WIDTH(18), .ADDR_W(2)) bus ();

    dsp_operand_feeder #(.WIDTH(18), .DEPTH(4), .ADDR_W(2), .PIPE_LAT(4)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef FEEDER_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [17:0] a);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = a + 18'h20;
        bus.in_d     = a + 18'h40;
    endtask

    initial begin
        bus.stall = 1'b0;
        drive(1'b0, 18'h0);
        tick();
        tick();
        // reset state
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_fill", 32'(bus.fill), 0);
        chk("rst_res_valid", 32'(bus.res_valid), 0);
        chk("rst_out_a", 32'(bus.out_a), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);
        chk("out_ce_run", 32'(bus.out_ce), 1);

        // 1: single triple, latency
        bus.in_valid = 1'b1; bus.in_a = 18'h3; bus.in_b = 18'h5; bus.in_d = 18'h7;
        tick();
        bus.in_valid = 1'b0;
        chk("t1_fill_push", 32'(bus.fill), 1);
        chk("t1_out_a_early", 32'(bus.out_a), 0);
        tick();
        chk("t1_out_a", 32'(bus.out_a), 32'h3);
        chk("t1_out_b", 32'(bus.out_b), 32'h5);
        chk("t1_out_d", 32'(bus.out_d), 32'h7);
        chk("t1_fill_pop", 32'(bus.fill), 0);
        chk("t1_rv_e1", 32'(bus.res_valid), 0);
        tick(); chk("t1_rv_e2", 32'(bus.res_valid), 0);
        tick(); chk("t1_rv_e3", 32'(bus.res_valid), 0);
        tick(); chk("t1_rv_e4", 32'(bus.res_valid), 1);
        tick(); chk("t1_rv_e5", 32'(bus.res_valid), 0);

        // 2: fill under stall, then drain in order
        bus.stall = 1'b1;
        #1;
        chk("t2_out_ce_stall", 32'(bus.out_ce), 0);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 18'(16 + k));
            tick();
        end
        chk("t2_fill_full", 32'(bus.fill), 4);
        chk("t2_in_ready_full", 32'(bus.in_ready), 0);
        drive(1'b1, 18'd21);
        tick();
        tick();
        chk("t2_fill_hold", 32'(bus.fill), 4);
        chk("t2_out_a_hold", 32'(bus.out_a), 32'h3);
        chk("t2_rv_hold", 32'(bus.res_valid), 0);
        bus.stall = 1'b0;
        tick();
        chk("t2_f1_out_a", 32'(bus.out_a), 17);
        chk("t2_f1_fill", 32'(bus.fill), 3);
        chk("t2_f1_in_ready", 32'(bus.in_ready), 1);
        tick();
        chk("t2_f2_out_a", 32'(bus.out_a), 18);
        chk("t2_f2_fill", 32'(bus.fill), 3);
        drive(1'b1, 18'd22);
        tick();
        chk("t2_f3_out_a", 32'(bus.out_a), 19);
        bus.in_valid = 1'b0;
        tick();
        chk("t2_f4_out_a", 32'(bus.out_a), 20);
        chk("t2_f4_rv", 32'(bus.res_valid), 1);
        tick();
        chk("t2_f5_out_a", 32'(bus.out_a), 21);
        chk("t2_f5_out_d", 32'(bus.out_d), 21 + 32'h40);
        chk("t2_f5_rv", 32'(bus.res_valid), 1);
        tick();
        chk("t2_f6_out_a", 32'(bus.out_a), 22);
        chk("t2_f6_rv", 32'(bus.res_valid), 1);
        chk("t2_f6_fill", 32'(bus.fill), 0);
        for (int k = 7; k <= 9; k++) begin
            tick();
            chk("t2_rv_tail", 32'(bus.res_valid), 1);
        end
        tick();
        chk("t2_rv_end", 32'(bus.res_valid), 0);

        // 3: stall 3 cycles with token at stage 2
        drive(1'b1, 18'h55);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_rv_stalled", 32'(bus.res_valid), 0);
            chk("t3_out_a_stalled", 32'(bus.out_a), 32'h55);
        end
        bus.stall = 1'b0;
        tick();
        chk("t3_rv_release", 32'(bus.res_valid), 1);
        tick();
        chk("t3_rv_after", 32'(bus.res_valid), 0);

        // 4: alternating push/idle gives bubbles
        drive(1'b1, 18'h100);
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("t4_q1_out_a", 32'(bus.out_a), 32'h100);
        drive(1'b1, 18'h101);
        tick();
        chk("t4_q2_out_a_bubble", 32'(bus.out_a), 32'h100);
        bus.in_valid = 1'b0;
        tick();
        chk("t4_q3_out_a", 32'(bus.out_a), 32'h101);
        tick();
        chk("t4_q4_out_a_bubble", 32'(bus.out_a), 32'h101);
        chk("t4_q4_rv", 32'(bus.res_valid), 1);
        tick(); chk("t4_q5_rv", 32'(bus.res_valid), 0);
        tick(); chk("t4_q6_rv", 32'(bus.res_valid), 1);
        tick(); chk("t4_q7_rv", 32'(bus.res_valid), 0);

        // 5: reset with fill=3 and two tokens in flight
        drive(1'b1, 18'h201); tick();
        drive(1'b1, 18'h202); tick();
        drive(1'b1, 18'h203); tick();
        bus.stall = 1'b1;
        drive(1'b1, 18'h204); tick();
        drive(1'b1, 18'h205); tick();
        bus.in_valid = 1'b0;
        chk("t5_fill_pre", 32'(bus.fill), 3);
        chk("t5_out_a_pre", 32'(bus.out_a), 32'h202);
        rst = 1'b1;
        tick();
        chk("t5_fill_rst", 32'(bus.fill), 0);
        chk("t5_rv_rst", 32'(bus.res_valid), 0);
        chk("t5_out_a_rst", 32'(bus.out_a), 0);
        chk("t5_out_d_rst", 32'(bus.out_d), 0);
        chk("t5_in_ready_rst", 32'(bus.in_ready), 0);
        rst = 1'b0;
        bus.stall = 1'b0;
        #1;
        chk("t5_in_ready_post", 32'(bus.in_ready), 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t5_no_stale_rv", 32'(bus.res_valid), 0);
        end
        chk("t5_fill_post", 32'(bus.fill), 0);

`ifdef FEEDER_FLUSH_EN
        // 6: flush with fill=2 under stall and a concurrent push
        drive(1'b1, 18'h77);
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("t6_out_a_pre", 32'(bus.out_a), 32'h77);
        bus.stall = 1'b1;
        drive(1'b1, 18'h81); tick();
        drive(1'b1, 18'h82); tick();
        chk("t6_fill_pre", 32'(bus.fill), 2);
        drive(1'b1, 18'h99);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("t6_fill_flush", 32'(bus.fill), 0);
        chk("t6_rv_flush", 32'(bus.res_valid), 0);
        chk("t6_out_a_flush", 32'(bus.out_a), 32'h77);
        bus.stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t6_rv_drained", 32'(bus.res_valid), 0);
        end
        chk("t6_out_a_end", 32'(bus.out_a), 32'h77);
        chk("t6_fill_end", 32'(bus.fill), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dsp_operand_feeder.md
Name: dsp_operand_feeder

Overview:
Upstream driver for the DSP48A1 slice pipeline registers. It accepts A/B/D operand triples on a valid/ready stream and buffers them in a small FIFO. It issues them, with a common clock-enable, into the slice's enabled input/pipeline registers. A token shift register tracks each operand through the slice latency, so the block flags exactly when the matching P result is valid.

Parameters:
WIDTH, 18, operand width of A, B and D
DEPTH, 4, FIFO entries (power of two, at least 2)
ADDR_W, 2, log2(DEPTH)
PIPE_LAT, 4, number of enabled register stages from out_a/out_b/out_d capture to P output, including the out_* register itself (at least 1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand triple present
in_ready  output  1  feeder can accept a triple
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_d  input  WIDTH  operand D (pre-adder)
out_a  output  WIDTH  registered operand A to the slice A input
out_b  output  WIDTH  registered operand B to the slice B input
out_d  output  WIDTH  registered operand D to the slice D input
out_ce  output  1  clock-enable to every slice pipeline register (drives clkE of all stages)
stall  input  1  result consumer not ready; freezes the slice pipeline
res_valid  output  1  slice P output holds a result belonging to a real operand
fill  output  ADDR_W+1  current FIFO occupancy, 0..DEPTH

Behaviour:
- Reset:
  - Applied on a rising clk edge with rst=1.
  - Clears FIFO pointers, sets fill=0, out_a/out_b/out_d=0, all tokens=0, res_valid=0.
  - in_ready=0 while rst=1, and 1 on the first cycle after rst deasserts.
  - A reset mid-operation discards all buffered and in-flight operands with no partial result.
- Push:
  - Occurs on an edge where in_valid && in_ready.
  - in_ready = (fill != DEPTH); there is no pass-through when full.
- Enable:
  - out_ce = !stall, combinational.
  - When out_ce=0, the following all hold their values: out_*, tokens, res_valid and FIFO read side. Pushes still occur.
- Pop:
  - Occurs on an edge where out_ce && fill!=0.
  - The head triple is loaded into out_a/out_b/out_d, and token[0] is loaded with 1.
  - On an edge where out_ce && fill==0, a bubble is issued: out_* hold their previous value and token[0] is loaded with 0.
- FIFO timing:
  - A word pushed into an empty FIFO is popped no earlier than the next edge, so the minimum push-to-out_* latency is 2 edges.
  - Simultaneous push and pop leaves fill unchanged; the order of data is preserved.
  - Pointers wrap modulo DEPTH.
- Token pipe:
  - token[i] shifts to token[i+1] on each edge where out_ce=1.
  - res_valid = token[PIPE_LAT-1].
  - A result is consumed on any edge where res_valid && !stall.
- Latency: a triple popped at enabled edge N produces res_valid after enabled edge N+PIPE_LAT-1. Stalled cycles add 1 to this latency per cycle.
- Throughput: with stall=0 and the FIFO kept non-empty, one result per cycle.
- Stall while full: in_ready=0 and fill=DEPTH are held; no data is lost or duplicated.

Optional Feature:
- Macro: FEEDER_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit).
  - An edge with flush=1 clears the FIFO (fill=0) and all tokens (res_valid=0), regardless of stall.
  - out_* hold their values.
  - A push in the same cycle as flush is dropped.
  - rst has priority over flush.
- When undefined: the port is absent and there is no flush logic.

Test Plan:
1. Reset, then push (a,b,d) = (0x00003, 0x00005, 0x00007) with stall=0 and PIPE_LAT=4 -> out_a=0x00003 two edges after the push; res_valid pulses for exactly 1 cycle, 3 edges later.
2. Push 6 triples back-to-back while stall=1 -> fill reaches 4 and in_ready=0 after the 4th; the 5th is held by the source. Release stall -> all 6 results come out in order, with res_valid high for 6 consecutive cycles.
3. Apply stall=1 for 3 cycles while a token sits at token[2] -> res_valid is delayed by exactly 3 cycles; out_a is unchanged during the stall.
4. Alternate push/idle with stall=0 -> bubbles give the res_valid pattern 1,0,1,0; out_* hold their values during bubbles.
5. Assert rst with fill=3 and 2 tokens in flight -> next cycle fill=0, res_valid=0, out_*=0; no stale res_valid appears afterwards.
6. (FEEDER_FLUSH_EN) Pulse flush for one cycle with fill=2, stall=1, in_valid=1 -> fill=0 and res_valid=0; the pushed word is dropped; out_* are unchanged.
